mem_rw: RTL and testbench

Byte-addressable, little-endian 32-bit memory used for both the data memory and the instruction memory of the core. It performs synchronous writes and combinational reads of bytes, halfwords or words. Reads can be zero- or sign-extended, and misaligned accesses are flagged. Every instance starts from the same fixed initial image.

---
 rtl/mem_rw.sv | 46 ++++
 tb/tb_mem_rw.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_rw.sv
// mem_rw: byte-addressable little-endian memory with comb read, sync write and alignment check
package mem_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} mem_width_t;
endpackage

module mem_rw
  import mem_pkg::*;
#(
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  mem_width_t           width,
  input  logic                 sign_extend,
  input  logic [AddrWidth-1:0] address,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 alignment_error
);
  localparam int Words = 2 ** (AddrWidth - 2);
  logic [31:0] mem [Words] = '{0: 32'h1234_5678, 1: 32'h0000_1111, default: 32'h0};
  logic is_byte, is_half;
  logic [AddrWidth-3:0] idx;
  logic [1:0] off, eff_off;
  logic [31:0] word, shifted, wdata;
  logic [3:0] be;
  assign is_byte = width == BYTE;
  assign is_half = width == HALF;
  assign idx = address[AddrWidth-1:2];
  assign off = address[1:0];
  assign alignment_error = is_byte ? 1'b0 : is_half ? off[0] : |off;
  // Misaligned reads fall back to the naturally aligned container.
  assign eff_off = is_byte ? off : is_half ? {off[1], 1'b0} : 2'b00;
  assign word = mem[idx];
  assign shifted = word >> {eff_off, 3'b000};
  assign data_out = is_byte ? {{24{sign_extend & shifted[7]}}, shifted[7:0]}
                  : is_half ? {{16{sign_extend & shifted[15]}}, shifted[15:0]}
                  : shifted;
  assign be = is_byte ? 4'b0001 << off : is_half ? 4'b0011 << off : 4'b1111;
  assign wdata = is_byte ? {4{data_in[7:0]}} : is_half ? {2{data_in[15:0]}} : data_in;
  always_ff @(posedge clk)
    if (!reset && write_enable && !alignment_error)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
endmodule

// File: tb/tb_mem_rw.sv
// tb_mem_rw: directed checks of mem_rw reads, writes, alignment and reset blocking
module tb_mem_rw;
  import mem_pkg::*;
  logic clk = 0, reset = 1, write_enable = 0, sign_extend = 0, alignment_error;
  mem_width_t width = WORD;
  logic [7:0] address = '0;
  logic [31:0] data_in = '0, data_out;
  int checks = 0, errors = 0;

  mem_rw #(.AddrWidth(8)) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .width(width),
    .sign_extend(sign_extend), .address(address), .data_in(data_in),
    .data_out(data_out), .alignment_error(alignment_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input mem_width_t w, input logic se, input logic [7:0] a);
    @(negedge clk);
    write_enable = 0;
    width = w;
    sign_extend = se;
    address = a;
    #1;
  endtask

  task automatic wr(input mem_width_t w, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    width = w;
    address = a;
    data_in = d;
    write_enable = 1;
    @(posedge clk);
    #1;
    write_enable = 0;
  endtask

  initial begin
    rd(WORD, 0, 8'd0);
    check("reset_read", data_out, 32'h1234_5678);
    check("reset_err", {31'b0, alignment_error}, 32'd0);
    reset = 0;
    rd(WORD, 0, 8'd5);
    check("mis_word_data", data_out, 32'h0000_1111);
    check("mis_word_err", {31'b0, alignment_error}, 32'd1);
    rd(HALF, 0, 8'd3);
    check("mis_half_data", data_out, 32'h0000_1234);
    check("mis_half_err", {31'b0, alignment_error}, 32'd1);
    rd(BYTE, 1, 8'd1);
    check("byte_rd_1", data_out, 32'h0000_0056);
    rd(BYTE, 1, 8'd3);
    check("byte_rd_3_err", {31'b0, alignment_error}, 32'd0);
    sign_extend = 1;
    wr(BYTE, 8'd0, 32'hFFFF_FF77);
    check("byte_wr_77", data_out, 32'h0000_0077);
    check("byte_wr_err", {31'b0, alignment_error}, 32'd0);
    rd(WORD, 0, 8'd0);
    check("word_after_77", data_out, 32'h1234_5677);
    wr(BYTE, 8'd0, 32'h0000_0078);
    wr(BYTE, 8'd3, 32'h0000_00CC);
    rd(BYTE, 1, 8'd3);
    check("neg_byte_sx", data_out, 32'hFFFF_FFCC);
    rd(BYTE, 0, 8'd3);
    check("neg_byte_zx", data_out, 32'h0000_00CC);
    rd(WORD, 0, 8'd0);
    check("word_after_cc", data_out, 32'hCC34_5678);
    @(negedge clk);
    width = WORD;
    address = 8'd2;
    data_in = 32'hDEAD_BEEF;
    write_enable = 1;
    #1;
    check("drop_err", {31'b0, alignment_error}, 32'd1);
    @(posedge clk);
    #1;
    write_enable = 0;
    rd(WORD, 0, 8'd0);
    check("drop_word0", data_out, 32'hCC34_5678);
    @(negedge clk);
    width = WORD;
    address = 8'd4;
    data_in = 32'hAAAA_AAAA;
    write_enable = 1;
    #2 reset = 1;
    @(posedge clk);
    #1;
    write_enable = 0;
    reset = 0;
    rd(WORD, 0, 8'd4);
    check("reset_blocks", data_out, 32'h0000_1111);
    wr(HALF, 8'd6, 32'h0000_ABCD);
    rd(WORD, 0, 8'd4);
    check("half_word4", data_out, 32'hABCD_1111);
    rd(HALF, 1, 8'd6);
    check("half_sx", data_out, 32'hFFFF_ABCD);
    rd(HALF, 0, 8'd6);
    check("half_zx", data_out, 32'h0000_ABCD);
    rd(mem_width_t'(2'd3), 1, 8'd4);
    check("unused_w_data", data_out, 32'hABCD_1111);
    rd(mem_width_t'(2'd3), 1, 8'd5);
    check("unused_w_err", {31'b0, alignment_error}, 32'd1);
    @(negedge clk);
    width = WORD;
    address = 8'd8;
    data_in = 32'h0BAD_F00D;
    write_enable = 1;
    #1;
    check("rdw_old", data_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    write_enable = 0;
    check("rdw_new", data_out, 32'h0BAD_F00D);
    wr(BYTE, 8'd9, 32'h0000_0055);
    rd(WORD, 0, 8'd8);
    check("byte_mid_merge", data_out, 32'h0BAD_550D);
    wr(HALF, 8'd9, 32'h0000_1234);
    rd(WORD, 0, 8'd8);
    check("mis_half_drop", data_out, 32'h0BAD_550D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
